// File: rtl/ctrl_mem_write_banked_if.sv
// Signal bundle between the word source (master) and the banked write controller (slave).
// Handshake: a word moves on every cycle where s_valid & s_ready are both 1; s_valid may change
// freely and s_ready depends only on controller state, never combinationally on s_valid.
interface ctrl_mem_write_banked_if #(
    parameter int MEM_ADDR_WIDTH = 3,
    parameter int MEM_SIZE       = 8,
    parameter int NUM_BANKS      = 4,
    parameter int BANK_SEL_WIDTH = 2,
    parameter int CNT_WIDTH      = $clog2(NUM_BANKS * MEM_SIZE + 1)
);
    logic                      s_valid;
    logic                      s_ready;
    logic                      mode;
    logic                      en_ext_ctrl;
    logic [MEM_ADDR_WIDTH-1:0] ext_addr;
    logic [BANK_SEL_WIDTH-1:0] ext_bank;
    logic                      buf_release;  // consumer release; 'release' is a reserved word
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [NUM_BANKS-1:0]      mem_wr_en;
    logic                      load_done;
    logic [CNT_WIDTH-1:0]      word_count;
    logic                      addr_err;
    logic                      state_dbg;    // 0 = FILL, 1 = FULL

    modport master (
        output s_valid, mode, en_ext_ctrl, ext_addr, ext_bank, buf_release,
        input  s_ready, mem_addr, mem_wr_en, load_done, word_count, addr_err, state_dbg
    );

    modport slave (
        input  s_valid, mode, en_ext_ctrl, ext_addr, ext_bank, buf_release,
        output s_ready, mem_addr, mem_wr_en, load_done, word_count, addr_err, state_dbg
    );
endinterface

// File: rtl/ctrl_mem_write_banked.sv
// Banked write controller: turns an accepted word stream into one-hot bank enables and a shared
// address, sequential or interleaved. Optional range check: CTRL_MEM_WRITE_RANGE_CHK_EN.
module ctrl_mem_write_banked #(
    parameter int MEM_ADDR_WIDTH = 3,
    parameter int MEM_SIZE       = 8,
    parameter int NUM_BANKS      = 4,
    parameter int BANK_SEL_WIDTH = 2,
    parameter int CNT_WIDTH      = $clog2(NUM_BANKS * MEM_SIZE + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    ctrl_mem_write_banked_if.slave  bus
);
    localparam int TOTAL = NUM_BANKS * MEM_SIZE;

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

    state_t                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_r, addr_nxt;
    logic [BANK_SEL_WIDTH-1:0] bank_r, bank_nxt, sel_bank;
    logic [CNT_WIDTH-1:0]      word_count_q;
    logic                      mode_r, eff_mode;
    logic                      load_done_q;
    logic                      xfer, last_word, in_range, s_ready_c;

    assign xfer      = bus.s_valid & (state_q == FILL);
    assign last_word = (word_count_q == CNT_WIDTH'(TOTAL - 1));
    // The first word of a frame follows the live mode; the rest follow the latched copy.
    assign eff_mode  = (word_count_q == '0) ? bus.mode : mode_r;
    assign sel_bank  = bus.en_ext_ctrl ? bus.ext_bank : bank_r;

    assign bus.s_ready    = s_ready_c;
    assign bus.mem_addr   = bus.en_ext_ctrl ? bus.ext_addr : addr_r;
    assign bus.load_done  = load_done_q;
    assign bus.word_count = word_count_q;
    assign bus.state_dbg  = state_q;

`ifdef CTRL_MEM_WRITE_RANGE_CHK_EN
    logic addr_err_q;

    assign in_range = !bus.en_ext_ctrl ||
                      ((32'(bus.ext_addr) < MEM_SIZE) && (32'(bus.ext_bank) < NUM_BANKS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_err_q <= 1'b0;
        end else if (xfer && !in_range) begin
            addr_err_q <= 1'b1;
        end
    end

    assign bus.addr_err = addr_err_q;
`else
    assign in_range     = 1'b1;
    assign bus.addr_err = 1'b0;
`endif

    // An out-of-range bank index simply matches none of the enables.
    always_comb begin
        bus.mem_wr_en = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bus.mem_wr_en[b] = xfer & in_range & (sel_bank == BANK_SEL_WIDTH'(b));
        end
    end

    always_comb begin
        addr_nxt = addr_r;
        bank_nxt = bank_r;
        if (!eff_mode) begin
            if (addr_r == MEM_ADDR_WIDTH'(MEM_SIZE - 1)) begin
                addr_nxt = '0;
                bank_nxt = (bank_r == BANK_SEL_WIDTH'(NUM_BANKS - 1)) ? '0 : bank_r + 1'b1;
            end else begin
                addr_nxt = addr_r + 1'b1;
            end
        end else begin
            if (bank_r == BANK_SEL_WIDTH'(NUM_BANKS - 1)) begin
                bank_nxt = '0;
                addr_nxt = (addr_r == MEM_ADDR_WIDTH'(MEM_SIZE - 1)) ? '0 : addr_r + 1'b1;
            end else begin
                bank_nxt = bank_r + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        s_ready_c = 1'b0;
        case (state_q)
            FILL: begin
                s_ready_c = 1'b1;
                if (xfer && last_word) state_d = FULL;
            end
            FULL: begin
                if (bus.buf_release) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= FILL;
            addr_r       <= '0;
            bank_r       <= '0;
            word_count_q <= '0;
            mode_r       <= 1'b0;
            load_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_done_q <= xfer && last_word;
            if (state_q == FULL && bus.buf_release) begin
                word_count_q <= '0;
                addr_r       <= '0;
                bank_r       <= '0;
            end else if (xfer) begin
                // No xfer happens in FULL, so the count rests at TOTAL there.
                word_count_q <= word_count_q + CNT_WIDTH'(1);
                if (word_count_q == '0) mode_r <= bus.mode;
                if (!bus.en_ext_ctrl) begin
                    addr_r <= addr_nxt;
                    bank_r <= bank_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_ctrl_mem_write_banked.sv
// Bench for ctrl_mem_write_banked: scenario tasks with inline checks plus a write scoreboard.
module tb_ctrl_mem_write_banked;
    localparam int MS    = 8;
    localparam int NB    = 4;
    localparam int AW    = 4;
    localparam int BSW   = 2;
    localparam int CW    = 6;
    localparam int TOTAL = NB * MS;

    logic clk = 1'b0;
    logic reset = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [NB+AW-1:0] exp_q[$];
    logic [NB+AW-1:0] exp_e;

    int   m_count = 0;
    int   m_int   = 0;
    logic m_mode  = 1'b0;
    logic m_full  = 1'b0;

    logic [NB-1:0] o_en;
    logic [AW-1:0] o_addr;

    ctrl_mem_write_banked_if #(
        .MEM_ADDR_WIDTH(AW), .MEM_SIZE(MS), .NUM_BANKS(NB), .BANK_SEL_WIDTH(BSW), .CNT_WIDTH(CW)
    ) bus ();

    ctrl_mem_write_banked #(
        .MEM_ADDR_WIDTH(AW), .MEM_SIZE(MS), .NUM_BANKS(NB), .BANK_SEL_WIDTH(BSW), .CNT_WIDTH(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end (got timeout, want completion)");
        $fatal(1);
    end

    // Scoreboard: every observed write must match the oldest expected write.
    always @(negedge clk) begin
        if (reset) begin
            if (exp_q.size() != 0) begin
                exp_e = exp_q.pop_front();
                n_cmp++;
                if ({bus.mem_wr_en, bus.mem_addr} !== exp_e) begin
                    n_err++;
                    $display("FAIL write: got en=%b addr=%0d, want en=%b addr=%0d",
                             bus.mem_wr_en, bus.mem_addr, exp_e[NB+AW-1:AW], exp_e[AW-1:0]);
                end
            end else if (bus.mem_wr_en !== '0) begin
                n_cmp++;
                n_err++;
                $display("FAIL stray_write: got en=%b, want en=0", bus.mem_wr_en);
            end
        end
    end

    task automatic send(input logic ext, input logic [BSW-1:0] eb, input logic [AW-1:0] ea,
                        output logic [NB-1:0] en, output logic [AW-1:0] ad);
        int b, a;
        logic eff, ok, was_full;
        logic [NB-1:0] one;
        bus.s_valid     = 1'b1;
        bus.en_ext_ctrl = ext;
        bus.ext_bank    = eb;
        bus.ext_addr    = ea;
        was_full = m_full;
        eff = (m_count == 0) ? bus.mode : m_mode;
        if (!was_full) begin
            if (ext) begin
                b = int'(eb);
                a = int'(ea);
            end else if (!eff) begin
                b = (m_int / MS) % NB;
                a = m_int % MS;
            end else begin
                b = m_int % NB;
                a = (m_int / NB) % MS;
            end
`ifdef CTRL_MEM_WRITE_RANGE_CHK_EN
            ok = !(ext && (a >= MS || b >= NB));
`else
            ok = 1'b1;
`endif
            one = '0;
            if (b < NB) one[b] = 1'b1;
            if (ok) exp_q.push_back({one, AW'(a)});
        end
        @(negedge clk);
        en = bus.mem_wr_en;
        ad = bus.mem_addr;
        @(posedge clk);
        #1;
        if (!was_full) begin
            if (m_count == 0) m_mode = eff;
            m_count++;
            if (!ext) m_int++;
            if (m_count == TOTAL) m_full = 1'b1;
        end
        bus.s_valid     = 1'b0;
        bus.en_ext_ctrl = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_release();
        bus.buf_release = 1'b1;
        @(posedge clk);
        #1;
        bus.buf_release = 1'b0;
        if (m_full) begin
            m_full  = 1'b0;
            m_count = 0;
            m_int   = 0;
        end
    endtask

    task automatic fill_to(input int n);
        logic [NB-1:0] en;
        logic [AW-1:0] ad;
        while (m_count < n) send(1'b0, '0, '0, en, ad);
    endtask

    task automatic test_reset();
        #1;
        if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", bus.s_ready); end
        n_cmp++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1);
        n_cmp += 7;
        if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", bus.s_ready); end
        if (bus.mem_wr_en !== '0) begin n_err++; $display("FAIL rst_wr_en: got %b want 0", bus.mem_wr_en); end
        if (bus.load_done !== 1'b0) begin n_err++; $display("FAIL rst_load_done: got %b want 0", bus.load_done); end
        if (bus.word_count !== '0) begin n_err++; $display("FAIL rst_count: got %0d want 0", bus.word_count); end
        if (bus.addr_err !== 1'b0) begin n_err++; $display("FAIL rst_addr_err: got %b want 0", bus.addr_err); end
        if (bus.mem_addr !== '0) begin n_err++; $display("FAIL rst_addr: got %0d want 0", bus.mem_addr); end
        if (bus.state_dbg !== 1'b0) begin n_err++; $display("FAIL rst_state: got %b want 0", bus.state_dbg); end
    endtask

    task automatic test_sequential();
        bus.mode = 1'b0;
        for (int k = 0; k < TOTAL; k++) begin
            if (k == 10) begin
                n_cmp++;
                if (bus.word_count !== 6'd10) begin n_err++; $display("FAIL seq_count10: got %0d want 10", bus.word_count); end
            end
            send(1'b0, '0, '0, o_en, o_addr);
            if (k == 8) begin
                n_cmp++;
                if (o_en !== 4'b0010 || o_addr !== 4'd0) begin
                    n_err++; $display("FAIL seq_word8: got en=%b addr=%0d want en=0010 addr=0", o_en, o_addr);
                end
            end
        end
        n_cmp += 4;
        if (bus.load_done !== 1'b1) begin n_err++; $display("FAIL seq_load_done: got %b want 1", bus.load_done); end
        if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL seq_ready: got %b want 0", bus.s_ready); end
        if (bus.word_count !== 6'd32) begin n_err++; $display("FAIL seq_count: got %0d want 32", bus.word_count); end
        if (bus.state_dbg !== 1'b1) begin n_err++; $display("FAIL seq_state: got %b want 1", bus.state_dbg); end
        idle(1);
        n_cmp += 2;
        if (bus.load_done !== 1'b0) begin n_err++; $display("FAIL seq_pulse_len: got %b want 0", bus.load_done); end
        if (bus.word_count !== 6'd32) begin n_err++; $display("FAIL seq_saturate: got %0d want 32", bus.word_count); end
    endtask

    task automatic test_release();
        for (int i = 0; i < 5; i++) begin
            send(1'b0, '0, '0, o_en, o_addr);
            n_cmp++;
            if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL rel_hold%0d: got ready=%b want 0", i, bus.s_ready); end
        end
        do_release();
        n_cmp += 3;
        if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready: got %b want 1", bus.s_ready); end
        if (bus.mem_addr !== '0) begin n_err++; $display("FAIL rel_addr: got %0d want 0", bus.mem_addr); end
        if (bus.word_count !== '0) begin n_err++; $display("FAIL rel_count: got %0d want 0", bus.word_count); end
        fill_to(3);
        do_release();
        n_cmp += 2;
        if (bus.word_count !== 6'd3) begin n_err++; $display("FAIL rel_in_fill: got %0d want 3", bus.word_count); end
        if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL rel_in_fill_ready: got %b want 1", bus.s_ready); end
        fill_to(TOTAL);
        do_release();
    endtask

    task automatic test_interleaved();
        bus.mode = 1'b1;
        for (int k = 0; k < TOTAL; k++) begin
            if (k == 10) bus.mode = 1'b0;
            send(1'b0, '0, '0, o_en, o_addr);
            if (k == 5) begin
                n_cmp++;
                if (o_en !== 4'b0010 || o_addr !== 4'd1) begin
                    n_err++; $display("FAIL il_word5: got en=%b addr=%0d want en=0010 addr=1", o_en, o_addr);
                end
            end
        end
        n_cmp++;
        if (bus.load_done !== 1'b1) begin n_err++; $display("FAIL il_load_done: got %b want 1", bus.load_done); end
        do_release();
    endtask

    task automatic test_ext_ctrl();
        fill_to(2);
        send(1'b1, 2'd3, 4'd6, o_en, o_addr);
        n_cmp++;
        if (o_en !== 4'b1000 || o_addr !== 4'd6) begin
            n_err++; $display("FAIL ext_write: got en=%b addr=%0d want en=1000 addr=6", o_en, o_addr);
        end
        idle(1);
        n_cmp++;
        if (bus.mem_addr !== 4'd2) begin n_err++; $display("FAIL ext_hold_addr: got %0d want 2", bus.mem_addr); end
        send(1'b1, 2'd1, 4'd9, o_en, o_addr);
        n_cmp += 3;
`ifdef CTRL_MEM_WRITE_RANGE_CHK_EN
        if (o_en !== 4'b0000) begin n_err++; $display("FAIL ext_oor_en: got %b want 0000", o_en); end
        if (bus.addr_err !== 1'b1) begin n_err++; $display("FAIL ext_addr_err: got %b want 1", bus.addr_err); end
`else
        if (o_en !== 4'b0010 || o_addr !== 4'd9) begin
            n_err++; $display("FAIL ext_pass: got en=%b addr=%0d want en=0010 addr=9", o_en, o_addr);
        end
        if (bus.addr_err !== 1'b0) begin n_err++; $display("FAIL ext_addr_err: got %b want 0", bus.addr_err); end
`endif
        if (bus.word_count !== 6'd4) begin n_err++; $display("FAIL ext_count: got %0d want 4", bus.word_count); end
    endtask

    task automatic test_gap_reset();
        while (m_count < 13) begin
            if ($urandom_range(0, 2) == 0) idle(1);
            else send(1'b0, '0, '0, o_en, o_addr);
        end
        n_cmp++;
        if (bus.word_count !== 6'd13) begin n_err++; $display("FAIL gap_count: got %0d want 13", bus.word_count); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp += 7;
        if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL arst_ready: got %b want 1", bus.s_ready); end
        if (bus.word_count !== '0) begin n_err++; $display("FAIL arst_count: got %0d want 0", bus.word_count); end
        if (bus.load_done !== 1'b0) begin n_err++; $display("FAIL arst_load_done: got %b want 0", bus.load_done); end
        if (bus.addr_err !== 1'b0) begin n_err++; $display("FAIL arst_addr_err: got %b want 0", bus.addr_err); end
        if (bus.mem_addr !== '0) begin n_err++; $display("FAIL arst_addr: got %0d want 0", bus.mem_addr); end
        if (bus.mem_wr_en !== '0) begin n_err++; $display("FAIL arst_wr_en: got %b want 0", bus.mem_wr_en); end
        if (bus.state_dbg !== 1'b0) begin n_err++; $display("FAIL arst_state: got %b want 0", bus.state_dbg); end
        exp_q.delete();
        m_count = 0;
        m_int   = 0;
        m_full  = 1'b0;
        m_mode  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.mode = 1'b0;
        send(1'b0, '0, '0, o_en, o_addr);
        n_cmp++;
        if (o_en !== 4'b0001 || o_addr !== 4'd0) begin
            n_err++; $display("FAIL arst_restart: got en=%b addr=%0d want en=0001 addr=0", o_en, o_addr);
        end
        fill_to(TOTAL);
        n_cmp++;
        if (bus.load_done !== 1'b1) begin n_err++; $display("FAIL arst_frame_done: got %b want 1", bus.load_done); end
        do_release();
    endtask

    initial begin
        bus.s_valid     = 1'b0;
        bus.mode        = 1'b0;
        bus.en_ext_ctrl = 1'b0;
        bus.ext_addr    = '0;
        bus.ext_bank    = '0;
        bus.buf_release = 1'b0;
        test_reset();
        test_sequential();
        test_release();
        test_interleaved();
        test_ext_ctrl();
        test_gap_reset();
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ctrl_mem_write_banked.md
# ctrl_mem_write_banked

Parametrised multi-bank write controller for the parallel datapath. It accepts a stream of words from the AXI-style master and generates one-hot per-bank write enables plus a shared write address. Banks are filled in either sequential or interleaved order. After a full frame it closes `s_ready` and holds until the consumer releases the buffer.

## Interface
- `MEM_ADDR_WIDTH`, 3: address width of each bank.
- `MEM_SIZE`, 8: words per bank; must be ≤ 2^MEM_ADDR_WIDTH.
- `NUM_BANKS`, 4: number of banks; ≥ 1.
- `BANK_SEL_WIDTH`, 2: width of the bank index; must be ≥ $clog2(NUM_BANKS) and ≥ 1.
- `CNT_WIDTH`, $clog2(NUM_BANKS*MEM_SIZE+1): width of the frame word counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  master has a word this cycle.
- `s_ready`  out  1  controller accepts a word this cycle.
- `mode`  in  1  fill order: 0 = sequential, 1 = interleaved.
- `en_ext_ctrl`  in  1  when 1, address and bank come from `ext_addr`/`ext_bank`.
- `ext_addr`  in  MEM_ADDR_WIDTH  external write address.
- `ext_bank`  in  BANK_SEL_WIDTH  external bank index.
- `release`  in  1  consumer has finished with the buffer; re-arms the controller.
- `mem_addr`  out  MEM_ADDR_WIDTH  write address, shared by all banks.
- `mem_wr_en`  out  NUM_BANKS  one-hot write enable.
- `load_done`  out  1  one-cycle pulse when the frame completes.
- `word_count`  out  CNT_WIDTH  number of words accepted in the current frame.
- `addr_err`  out  1  sticky out-of-range error flag (see Configuration).

## Operation
- A frame is TOTAL = NUM_BANKS*MEM_SIZE accepted words. A word is accepted when `xfer = s_valid & s_ready`.
- FSM states:
  - FILL (reset state): `s_ready`=1.
  - FULL: `s_ready`=0.
- FILL → FULL on the edge where `xfer` occurs and `word_count == TOTAL-1`.
- FULL → FILL on the edge where `release`=1. That edge clears `word_count`, `addr_r` and `bank_r` to 0. `release` is ignored while in FILL.
- Mode latch:
  - `mode` is latched into `mode_r` on the edge of any `xfer` with `word_count`==0.
  - The first word of a frame uses the live `mode`; the rest of the frame uses `mode_r`.
  - Changes to `mode` mid-frame are ignored.
- Internal counters `addr_r` and `bank_r` advance on each `xfer` only when `en_ext_ctrl`=0:
  - Sequential: `addr_r` increments. At MEM_SIZE-1 it wraps to 0 and `bank_r` increments. `bank_r` wraps to 0 after NUM_BANKS-1.
  - Interleaved: `bank_r` increments. At NUM_BANKS-1 it wraps to 0 and `addr_r` increments. `addr_r` wraps to 0 after MEM_SIZE-1.
- `en_ext_ctrl`=1:
  - `mem_addr` = `ext_addr`; the bank is selected by `ext_bank`.
  - `addr_r` and `bank_r` hold.
  - `word_count` still increments on every `xfer`.
- `mem_addr` is combinational: `en_ext_ctrl ? ext_addr : addr_r`.
- `mem_wr_en[b]` = `xfer & (sel_bank == b)`. An out-of-range `sel_bank` drives no enable.
- `word_count` increments by 1 per `xfer` and saturates at TOTAL in FULL.
- `load_done` is registered. It is 1 for exactly the cycle after the FILL→FULL edge.

## Timing
- Reset values: `s_ready`=1, `mem_addr`=0 (when `en_ext_ctrl`=0), `mem_wr_en`=0, `load_done`=0, `word_count`=0, `addr_err`=0. State = FILL, `mode_r`=0.
- Reset asserted mid-frame clears all state immediately, without waiting for a clock edge. Words already written to the banks are abandoned.
- Write latency is zero: `mem_wr_en` and `mem_addr` are valid in the same cycle as `xfer`.
- The final word of a frame is written in its own cycle. `s_ready` is 0 from the next cycle.
- Back-to-back: one word per cycle while `s_valid`=1. No bubbles occur within a frame.
- If `release` arrives in the cycle after the last `xfer`, `s_ready` returns to 1 the cycle after that. The minimum FULL residency is 1 cycle.

## Configuration
- `CTRL_MEM_WRITE_RANGE_CHK_EN` defined:
  - When `en_ext_ctrl`=1, an `xfer` with `ext_addr` ≥ MEM_SIZE or `ext_bank` ≥ NUM_BANKS drives no `mem_wr_en` bit. `word_count` still increments.
  - `addr_err` is set on the next edge and stays set until reset.
- Not defined:
  - `addr_err` is tied to 0.
  - `ext_addr` passes through unchecked.
  - An out-of-range `ext_bank` still drives no enable bit, because the one-hot decode matches no bank.

## Test plan
- Sequential fill, defaults, `s_valid` held 1: 32 `xfer`s. Words 0-7 go to bank0 at addr 0-7, then bank1, and so on. `load_done` pulses in the cycle after word 31. `s_ready`=0 from that same cycle and `word_count`=32.
- Interleaved fill (`mode`=1): word k writes bank k%4 at addr k/4. Word 5 → `mem_wr_en`=4'b0010, `mem_addr`=1. `mode` toggled at word 10 has no effect on the fill order.
- Release handshake: hold `release`=0 for 5 cycles in FULL → `s_ready` stays 0. Pulse `release` → `s_ready`=1 the next cycle, `mem_addr`=0, `word_count`=0. A `release` pulse during FILL has no effect.
- External control: `en_ext_ctrl`=1, `ext_bank`=3, `ext_addr`=6 → `mem_wr_en`=4'b1000, `mem_addr`=6, and `addr_r` is unchanged when `en_ext_ctrl` is dropped. With the macro on, `ext_addr`=9 under `MEM_ADDR_WIDTH`=4 gives no enable and sets `addr_err`=1.
- Gapped `s_valid` plus asynchronous reset: random `s_valid` gaps → address advances only on `xfer`. Reset asserted at `word_count`=13, between clock edges → all outputs return to their reset values immediately, and the next frame starts at bank0/addr0.
